// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole autoplayer and the display driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mole_pkg;

    localparam int NUM_BTN = 8;
    localparam int NUM_SEG = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REACT   = 2'd1,
        ST_PRESS   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Active-low gfedcba glyphs for hex digits, entry i is digit i (listed F down to 0).
    localparam logic [15:0][NUM_SEG-1:0] GLYPH_LO = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Number of lit (low) segments in an active-low pattern.
    function automatic logic [2:0] count_low(input logic [NUM_SEG-1:0] seg);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_SEG; i++) begin
            n = n + {2'b00, ~seg[i]};
        end
        return n;
    endfunction

    // Position of the lowest lit segment; only meaningful when exactly one is lit.
    function automatic logic [2:0] first_low(input logic [NUM_SEG-1:0] seg);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (!seg[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mole_autoplayer_seg7_glyph_decoder.sv
// Maps an active-low 7-segment pattern to {valid, hex value} using the shared glyph table.
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows input every cycle.
// Only present when MOLE_AUTOPLAYER_SCORE_DECODE_EN is defined, so the default build carries no decoder.
`ifdef MOLE_AUTOPLAYER_SCORE_DECODE_EN
module seg7_glyph_decoder
    import mole_pkg::*;
(
    input  logic [NUM_SEG-1:0] seg,
    output logic               hit,
    output logic [3:0]         value
);

    // Linear search of the 16 glyphs; glyphs are unique so the first match is the only match.
    always_comb begin
        hit   = 1'b0;
        value = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && (seg == GLYPH_LO[i])) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule
`endif

// File: rtl/mole_autoplayer.sv
// Watches the game display, presses the button under each lit mole, handles start presses and score readout.
// Latency: 1 cycle input register, then REACT_CYCLES to press; press and release each last HOLD_CYCLES.
// Backpressure: none; requests arriving while busy are either pending (start) or re-evaluated in IDLE (moles).
// Optional: define MOLE_AUTOPLAYER_SCORE_DECODE_EN to decode the game-over score glyph.
module mole_autoplayer
    import mole_pkg::*;
#(
    parameter int REACT_CYCLES = 6,
    parameter int HOLD_CYCLES  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               start_req,
    input  logic [NUM_SEG-1:0] seg_in,
    input  logic               dp_in,
    output logic [NUM_BTN-1:0] btn_out,
    output logic               busy,
    output logic [2:0]         mole_idx,
    output logic [7:0]         hit_count,
    output logic [3:0]         score_out,
    output logic               score_valid,
    output logic               err_pattern
);

    // Reject out-of-range timing at elaboration; the hold limit keeps presses longer than the game's debounce.
    if (REACT_CYCLES < 1 || REACT_CYCLES > 65535) begin : g_bad_react
        $error("mole_autoplayer: REACT_CYCLES must be in 1..65535");
    end
    if (HOLD_CYCLES < 5 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("mole_autoplayer: HOLD_CYCLES must be in 5..65535");
    end

    localparam logic [15:0] REACT_LOAD = 16'(REACT_CYCLES);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES);
    localparam logic [NUM_BTN-1:0] BTN_START = {{(NUM_BTN-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [NUM_BTN-1:0] btn_q, btn_d;
    logic               busy_q, busy_d;
    logic [2:0]         mole_idx_q, mole_idx_d;
    logic [7:0]         hit_q, hit_d;
    logic               err_q, err_d;
    logic [NUM_SEG-1:0] seg_q;
    logic               dp_q;

    logic [2:0]         low_cnt;
    logic [2:0]         pat_idx;
    logic               pat_legal;
    logic               take_start;

    // Classify the registered display: a running frame with exactly one lit segment is a mole.
    always_comb begin
        low_cnt   = count_low(seg_q);
        pat_idx   = first_low(seg_q);
        pat_legal = dp_q && (low_cnt == 3'd1);
    end

    // Next-state logic for the press sequencer, hit counter, pending start and sticky error.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        btn_d      = btn_q;
        mole_idx_d = mole_idx_q;
        hit_d      = hit_q;
        take_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    // Start press bypasses the reaction delay and restarts the hit tally.
                    state_d    = ST_PRESS;
                    cnt_d      = HOLD_LOAD;
                    btn_d      = BTN_START;
                    hit_d      = 8'd0;
                    take_start = 1'b1;
                end else if (enable && pat_legal) begin
                    state_d    = ST_REACT;
                    cnt_d      = REACT_LOAD;
                    mole_idx_d = pat_idx;
                end
            end
            ST_REACT: begin
                // Mole vanished, moved or game ended: drop it without pressing anything.
                if (!pat_legal || (pat_idx != mole_idx_q)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'd1) begin
                    state_d = ST_PRESS;
                    cnt_d   = HOLD_LOAD;
                    btn_d   = BTN_START << mole_idx_q;
                    if (hit_q != 8'hFF) begin
                        hit_d = hit_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_PRESS: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_RELEASE;
                    cnt_d   = HOLD_LOAD;
                    btn_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
                btn_d   = '0;
            end
        endcase

        // A request landing in the same cycle the start is consumed stays pending for the next press.
        pend_d = (pend_q && !take_start) || start_req;
        busy_d = (state_d != ST_IDLE);
        // A blank running display counts as illegal too, including the input register's reset value.
        err_d  = err_q || (dp_q && (low_cnt != 3'd1));
    end

`ifdef MOLE_AUTOPLAYER_SCORE_DECODE_EN
    logic [3:0] score_q, score_d;
    logic       score_vld_q, score_vld_d;
    logic       dec_hit;
    logic [3:0] dec_val;

    seg7_glyph_decoder u_glyph (
        .seg   (seg_q),
        .hit   (dec_hit),
        .value (dec_val)
    );

    // During game over, latch each recognised glyph; an unrecognised frame only clears the valid flag.
    always_comb begin
        score_d     = score_q;
        score_vld_d = score_vld_q;
        if (!dp_q) begin
            if (dec_hit) begin
                score_d     = dec_val;
                score_vld_d = 1'b1;
            end else begin
                score_vld_d = 1'b0;
            end
        end
    end

    // Score registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q     <= 4'd0;
            score_vld_q <= 1'b0;
        end else begin
            score_q     <= score_d;
            score_vld_q <= score_vld_d;
        end
    end

    assign score_out   = score_q;
    assign score_valid = score_vld_q;
`else
    assign score_out   = 4'd0;
    assign score_valid = 1'b0;
`endif

    // All sequencer state, registered outputs and the display input register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            pend_q     <= 1'b0;
            btn_q      <= '0;
            busy_q     <= 1'b0;
            mole_idx_q <= 3'd0;
            hit_q      <= 8'd0;
            err_q      <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            btn_q      <= btn_d;
            busy_q     <= busy_d;
            mole_idx_q <= mole_idx_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            seg_q      <= seg_in;
            dp_q       <= dp_in;
        end
    end

    assign btn_out     = btn_q;
    assign busy        = busy_q;
    assign mole_idx    = mole_idx_q;
    assign hit_count   = hit_q;
    assign err_pattern = err_q;

endmodule

// File: tb/tb_mole_autoplayer.sv
// Self-checking bench for mole_autoplayer: directed scenarios followed by random display traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_mole_autoplayer;

    localparam int REACT = 6;
    localparam int HOLD  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       start_req;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [7:0] btn_out;
    logic       busy;
    logic [2:0] mole_idx;
    logic [7:0] hit_count;
    logic [3:0] score_out;
    logic       score_valid;
    logic       err_pattern;

    always #5 clk = ~clk;

    mole_autoplayer #(
        .REACT_CYCLES (REACT),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start_req   (start_req),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .btn_out     (btn_out),
        .busy        (busy),
        .mole_idx    (mole_idx),
        .hit_count   (hit_count),
        .score_out   (score_out),
        .score_valid (score_valid),
        .err_pattern (err_pattern)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: timestamps of when a reaction / press window began, not counters.
    int         edge_n  = 0;
    bit         m_win   = 0;
    int         m_w     = 0;
    logic [7:0] m_mask  = 8'h00;
    bit         m_react = 0;
    int         m_r     = 0;
    int         m_tgt   = 0;
    logic [6:0] m_seg   = 7'h7F;
    bit         m_dp    = 1;
    bit         m_pend  = 0;
    int         m_hit   = 0;
    int         m_idx   = 0;
    bit         m_err   = 0;
    int         m_score = 0;
    bit         m_sv    = 0;
    bit         m_legal;
    int         m_pidx;
    bit         m_took;
    bit         m_found;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    function automatic int nzeros(input logic [6:0] s);
        int n = 0;
        for (int i = 0; i < 7; i++) if (s[i] == 1'b0) n++;
        return n;
    endfunction

    function automatic int lowz(input logic [6:0] s);
        for (int i = 0; i < 7; i++) if (s[i] == 1'b0) return i;
        return 0;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_win = 0; m_react = 0; m_pend = 0; m_hit = 0; m_idx = 0;
            m_err = 0; m_score = 0; m_sv = 0; m_mask = 8'h00;
            m_seg = 7'h7F; m_dp = 1;
        end else begin
            m_legal = m_dp && (nzeros(m_seg) == 1);
            m_pidx  = lowz(m_seg);
            m_took  = 0;
            if (m_win) begin
                if (edge_n - m_w == 2 * HOLD) m_win = 0;
            end else if (m_react) begin
                if (!m_legal || m_pidx != m_tgt) begin
                    m_react = 0;
                end else if (edge_n - m_r == REACT) begin
                    m_react = 0; m_win = 1; m_w = edge_n;
                    m_mask = 8'h01 << m_tgt;
                    if (m_hit < 255) m_hit++;
                end
            end else if (m_pend) begin
                m_win = 1; m_w = edge_n; m_mask = 8'h01; m_hit = 0; m_took = 1;
            end else if (enable && m_legal) begin
                m_react = 1; m_r = edge_n; m_tgt = m_pidx; m_idx = m_pidx;
            end
            m_pend = (m_pend && !m_took) || start_req;
            if (m_dp && nzeros(m_seg) != 1) m_err = 1;
`ifdef MOLE_AUTOPLAYER_SCORE_DECODE_EN
            if (!m_dp) begin
                m_found = 0;
                for (int j = 0; j < 16; j++) begin
                    if (glyph[j] == m_seg) begin m_found = 1; m_score = j; end
                end
                m_sv = m_found;
            end
`endif
            m_seg = seg_in;
            m_dp  = dp_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] eb;
        eb = (m_win && (edge_n - m_w) < HOLD) ? m_mask : 8'h00;
        chk("btn_out", btn_out, eb);
        chk("busy", busy, m_win || m_react);
        chk("mole_idx", mole_idx, m_idx);
        chk("hit_count", hit_count, m_hit);
        chk("err_pattern", err_pattern, m_err);
        chk("score_out", score_out, m_score);
        chk("score_valid", score_valid, m_sv);
    endtask

    // One clock: let the edge happen, then sample mid-cycle against the model.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) step();
        chk("reach_idle", busy, 1'b0);
    endtask

    initial begin
        int cnt;
        int cnt2;
        int lat;
        int r;

        rst = 1; enable = 0; start_req = 0; seg_in = 7'h7F; dp_in = 1;
        @(negedge clk);
        step(); step();
        chk("reset_btn", btn_out, 8'h00);
        chk("reset_hit", hit_count, 8'd0);
        chk("reset_err", err_pattern, 1'b0);
        rst = 0;

        // Start press: 8 cycles of bit 0, 8 released, then idle with zero hits.
        start_req = 1; step(); start_req = 0;
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (btn_out == 8'h01) cnt++;
            else if (busy) cnt2++;
        end
        chk("start_press_len", cnt, HOLD);
        chk("start_release_len", cnt2, HOLD);
        chk("start_busy_end", busy, 1'b0);
        chk("start_hit", hit_count, 8'd0);

        // Single mole at index 3: press lands 1+1+REACT cycles after the input change.
        enable = 1; seg_in = 7'b1110111;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (btn_out != 8'h00) begin lat = i; break; end
        end
        chk("mole_latency", lat, 2 + REACT);
        chk("mole_btn", btn_out, 8'h08);
        chk("mole_idx3", mole_idx, 3'd3);
        cnt = 1;
        for (int i = 0; i < 20 && btn_out == 8'h08; i++) begin
            step();
            if (btn_out == 8'h08) cnt++;
        end
        chk("mole_press_len", cnt, HOLD);
        chk("mole_hit", hit_count, 8'd1);
        enable = 0;
        wait_idle();

        // Abort: mole moves from 3 to 5 during REACT; only index 5 is pressed.
        enable = 1;
        step(); step(); step();
        seg_in = 7'b1011111;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (btn_out != 8'h00) begin lat = i; break; end
        end
        chk("abort_btn", btn_out, 8'h20);
        chk("abort_idx", mole_idx, 3'd5);
        chk("abort_hit", hit_count, 8'd2);
        enable = 0;
        wait_idle();

        // Illegal running pattern: never pressed, error sticks.
        enable = 1; seg_in = 7'b1110011;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (btn_out != 8'h00) cnt++;
        end
        chk("illegal_no_press", cnt, 0);
        chk("illegal_err", err_pattern, 1'b1);

        // Game over: score glyph 2, then blank.
        dp_in = 0; seg_in = 7'b0100100;
        step(); step(); step();
`ifdef MOLE_AUTOPLAYER_SCORE_DECODE_EN
        chk("score_val", score_out, 4'd2);
        chk("score_vld", score_valid, 1'b1);
`else
        chk("score_val_off", score_out, 4'd0);
        chk("score_vld_off", score_valid, 1'b0);
`endif
        seg_in = 7'h7F;
        step(); step(); step();
        chk("score_vld_blank", score_valid, 1'b0);
        chk("gameover_err_sticky", err_pattern, 1'b1);

        // Saturation: repeat the same mole until the tally saturates.
        dp_in = 1; seg_in = 7'b1111011; enable = 1;
        for (int i = 0; i < 7500 && hit_count != 8'hFF; i++) step();
        chk("sat_reach", hit_count, 8'hFF);
        for (int i = 0; i < 30 && btn_out != 8'h00; i++) step();
        for (int i = 0; i < 40 && btn_out == 8'h00; i++) step();
        chk("sat_repress", btn_out, 8'h04);
        chk("sat_hold", hit_count, 8'hFF);

        // Two start requests during this press merge into a single start press.
        step(); start_req = 1; step(); start_req = 0; step(); step();
        start_req = 1; step(); start_req = 0;
        for (int i = 0; i < 60 && btn_out != 8'h01; i++) step();
        chk("pend_start_btn", btn_out, 8'h01);
        chk("pend_start_hit", hit_count, 8'd0);
        enable = 0;
        for (int i = 0; i < 20 && btn_out == 8'h01; i++) step();
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (btn_out == 8'h01) cnt++;
        end
        chk("pend_single", cnt, 0);

        // Random display traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                seg_in = ~(7'h01 << $urandom_range(0, 6));
            end else if (r < 8) begin
                seg_in = 7'($urandom);
            end else if (r < 9) begin
                seg_in = glyph[$urandom_range(0, 15)];
            end
            if ($urandom_range(0, 49) == 0) dp_in = ~dp_in;
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            start_req = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; start_req = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_autoplayer.md
MOLE_AUTOPLAYER -- requirements
Module: mole_autoplayer

Interface
REQ-001 Parameter REACT_CYCLES, default 6: cycles from mole detection to button press; legal range 1..65535, checked at elaboration.
REQ-002 Parameter HOLD_CYCLES, default 8: press length and release length; legal range 5..65535 (exceeds the 4-cycle button debounce).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  permits autonomous mole presses.
REQ-006 start_req  input  1  single-cycle request to press the start button (bit 0).
REQ-007 seg_in  input  7  active-low segment pattern from the game display.
REQ-008 dp_in  input  1  display decimal point; 1 = game running, 0 = game over (score shown).
REQ-009 btn_out  output  8  button drive into game ui_in; at most one bit high.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 mole_idx  output  3  segment index of the last mole targeted.
REQ-012 hit_count  output  8  number of mole presses issued since the last start press.
REQ-013 score_out  output  4  decoded game-over score nibble.
REQ-014 score_valid  output  1  score_out holds a legal glyph decode.
REQ-015 err_pattern  output  1  sticky flag: illegal running pattern seen.

Function
REQ-016 seg_in and dp_in are registered once; all decisions use the registered copies (1-cycle input latency).
REQ-017 A running pattern is legal when the registered dp is 1 and exactly one seg bit is 0; its index is that bit position (0..6).
REQ-018 FSM states are IDLE, REACT, PRESS and RELEASE, with a 16-bit down-counter.
REQ-019 IDLE: a pending start (REQ-024) takes priority -> PRESS with btn_out=8'h01, no REACT; counter = HOLD_CYCLES.
REQ-020 IDLE: otherwise, if enable=1 and the pattern is legal -> REACT; mole_idx captures the index; counter = REACT_CYCLES.
REQ-021 REACT: the counter decrements each cycle; at 1 -> PRESS with btn_out = 1<<mole_idx; hit_count increments, saturating at 255.
REQ-022 REACT: if registered dp goes 0 or the pattern index changes, the press is aborted -> IDLE, btn_out unchanged at 0, no increment.
REQ-023 PRESS lasts exactly HOLD_CYCLES cycles, then RELEASE with btn_out=0 for exactly HOLD_CYCLES cycles, then IDLE; neither phase is truncated by dp, enable or pattern changes.
REQ-024 start_req sets a pending flag; the flag clears on entering PRESS for the start press; repeated requests while pending merge into one.
REQ-025 Entering PRESS for a start press clears hit_count to 0 in the same cycle.
REQ-026 A mole remaining after RELEASE, including a repeat of the same index, is pressed again through REACT; there is no same-pattern suppression.
REQ-027 err_pattern sets when registered dp=1 and the number of low seg bits is not 1; only rst clears it.
REQ-028 enable=0 only blocks the IDLE->REACT transition; operations in flight complete.

Reset
REQ-029 On rst: state=IDLE, counter=0, pending start=0, btn_out=0, busy=0, mole_idx=0, hit_count=0, score_out=0, score_valid=0, err_pattern=0, input registers=7'h7F and dp=1.
REQ-030 rst asserted mid-PRESS drops btn_out to 0 on the next edge.

Configuration
REQ-031 Macro MOLE_AUTOPLAYER_SCORE_DECODE_EN defined: while registered dp=0, seg is decoded against the 16 hex glyphs; on a match score_out=value and score_valid=1 (registered, 1 cycle after the input register); on no match score_valid=0 and score_out holds.
REQ-032 Macro undefined: score_out=0 and score_valid=0 permanently; no decoder logic is present.

Structure
REQ-033 Package mole_pkg holds the FSM state enum, NUM_BTN=8, NUM_SEG=7 and the 16-entry active-low glyph table shared with the display driver.
REQ-034 Sub-module seg7_glyph_decoder (combinational 7-bit to {valid, 4-bit}) is instantiated only under MOLE_AUTOPLAYER_SCORE_DECODE_EN.

Verification
REQ-035 Start press: rst, then start_req pulse -> btn_out=8'h01 for 8 cycles, then 0 for 8 cycles, busy then low; hit_count=0.
REQ-036 Single mole: enable=1, seg_in=7'b1110111, dp=1 -> mole_idx=3; btn_out=8'h08 starting 1+1+6 cycles after input change for 8 cycles; hit_count=1.
REQ-037 Abort: seg_in changes from index 3 to index 5 at REACT cycle 3 -> no press; new REACT for index 5; btn_out=8'h20.
REQ-038 Illegal pattern: dp=1, seg_in=7'b1110011 -> err_pattern=1 and stays 1; no press issued.
REQ-039 Game over (macro on): dp=0, seg_in=7'b0100100 -> score_out=2, score_valid=1; seg_in=7'b1111111 -> score_valid=0. With macro off -> both outputs stay 0.
REQ-040 Saturation and pending start: 256 mole presses -> hit_count=255; start_req pulsed twice during PRESS -> exactly one start press after RELEASE, and hit_count returns to 0.
